led_flow_ctrl: RTL and testbench

LED_FLOW_CTRL -- requirements
Module: led_flow_ctrl

---
 rtl/led_pkg.sv | 16 +
 rtl/led_step_tick.sv | 46 ++++
 rtl/led_flow_ctrl.sv | 129 ++++++++++++
 tb/tb_led_flow_ctrl.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/led_pkg.sv
// Shared definitions for the LED flow controller: pattern mode encodings
// and a one-hot test used for pattern self-recovery.
package led_pkg;

  typedef enum logic [1:0] {
    MODE_ROL  = 2'b00,
    MODE_ROR  = 2'b01,
    MODE_PING = 2'b10,
    MODE_FILL = 2'b11
  } led_mode_e;

  function automatic logic is_onehot(input logic [31:0] v);
    return (v != 32'd0) && ((v & (v - 32'd1)) == 32'd0);
  endfunction

endpackage

// File: rtl/led_step_tick.sv
// Step period counter: counts 0..P-1 with P = STEP_CYC >> speed and flags
// the cycle whose rising edge performs a pattern step.
module led_step_tick
  import led_pkg::*;
#(
  parameter int unsigned STEP_CYC = 50_000_000
) (
  input  logic       clk50MHz,
  input  logic       rst,
  input  logic       clr,
  input  logic       hold,
  input  logic [1:0] speed,
  output logic       tick
);

  localparam int unsigned CNT_W = $clog2(STEP_CYC);

  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      w_per_m1;
  logic [31:0]      w_cnt_ext;
  logic             w_wrap;

  // >= compare lets a shortened period end immediately instead of wrapping
  always_comb begin
    w_per_m1  = (32'(STEP_CYC) >> speed) - 32'd1;
    w_cnt_ext = 32'(r_cnt);
    w_wrap    = (w_cnt_ext >= w_per_m1);
    tick      = w_wrap & ~clr & ~hold;
  end

  // Period counter; clear wins over hold
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (clr) begin
      r_cnt <= '0;
    end else if (hold) begin
      r_cnt <= r_cnt;
    end else if (w_wrap) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CNT_W'(1'b1);
    end
  end

endmodule

// File: rtl/led_flow_ctrl.sv
// LED pattern generator: rotate, ping-pong and fill patterns advanced by a
// clock-enable step tick, with pause and mode-change reload.
module led_flow_ctrl
  import led_pkg::*;
#(
  parameter int unsigned LED_W    = 8,
  parameter int unsigned STEP_CYC = 50_000_000
) (
  input  logic             clk50MHz,
  input  logic             rst,
  input  logic [1:0]       mode,
  input  logic [1:0]       speed,
  input  logic             pause,
  output logic [LED_W-1:0] led,
  output logic             step
);

  localparam logic [LED_W-1:0] LED_ONE = {{(LED_W-1){1'b0}}, 1'b1};

  logic [LED_W-1:0] r_led;
  logic             r_dir_left;
  led_mode_e        r_mode;
  logic             r_run;
  logic             r_step;

  logic [LED_W-1:0] w_led_nxt;
  logic             w_dir_nxt;
  logic             w_onehot;
  logic             w_mode_chg;
  logic             w_tick;

  // The first edge after reset only adopts the current mode, so it is
  // neither a mode change nor a counted cycle.
  assign w_mode_chg = r_run && (led_mode_e'(mode) != r_mode);

  led_step_tick #(
    .STEP_CYC (STEP_CYC)
  ) u_tick (
    .clk50MHz (clk50MHz),
    .rst      (rst),
    .clr      (w_mode_chg),
    .hold     (pause | ~r_run),
    .speed    (speed),
    .tick     (w_tick)
  );

  // Next pattern value and direction for the coming step
  always_comb begin
    w_led_nxt = r_led;
    w_dir_nxt = r_dir_left;
    w_onehot  = is_onehot(32'(r_led));
    case (r_mode)
      MODE_ROL: begin
        if (w_onehot) begin
          w_led_nxt = {r_led[LED_W-2:0], r_led[LED_W-1]};
        end else begin
          w_led_nxt = LED_ONE;
        end
      end
      MODE_ROR: begin
        if (w_onehot) begin
          w_led_nxt = {r_led[0], r_led[LED_W-1:1]};
        end else begin
          w_led_nxt = LED_ONE;
        end
      end
      MODE_PING: begin
        if (!w_onehot) begin
          w_led_nxt = LED_ONE;
          w_dir_nxt = 1'b1;
        end else if (r_dir_left) begin
          if (r_led[LED_W-1]) begin
            w_led_nxt = r_led >> 1;
            w_dir_nxt = 1'b0;
          end else begin
            w_led_nxt = r_led << 1;
          end
        end else begin
          if (r_led[0]) begin
            w_led_nxt = r_led << 1;
            w_dir_nxt = 1'b1;
          end else begin
            w_led_nxt = r_led >> 1;
          end
        end
      end
      MODE_FILL: begin
        if (&r_led) begin
          w_led_nxt = LED_ONE;
        end else begin
          w_led_nxt = {r_led[LED_W-2:0], 1'b1};
        end
      end
      default: begin
        w_led_nxt = LED_ONE;
        w_dir_nxt = 1'b1;
      end
    endcase
  end

  // Pattern state; a mode change reloads even while paused
  always_ff @(posedge clk50MHz or posedge rst) begin
    if (rst) begin
      r_led      <= LED_ONE;
      r_dir_left <= 1'b1;
      r_mode     <= MODE_ROL;
      r_run      <= 1'b0;
      r_step     <= 1'b0;
    end else begin
      r_run  <= 1'b1;
      r_mode <= led_mode_e'(mode);
      if (w_mode_chg) begin
        r_led      <= LED_ONE;
        r_dir_left <= 1'b1;
        r_step     <= 1'b0;
      end else if (w_tick) begin
        r_led      <= w_led_nxt;
        r_dir_left <= w_dir_nxt;
        r_step     <= 1'b1;
      end else begin
        r_step     <= 1'b0;
      end
    end
  end

  assign led  = r_led;
  assign step = r_step;

endmodule

// File: tb/tb_led_flow_ctrl.sv
// Bench for led_flow_ctrl: 8-LED and 4-LED instances on shared stimulus,
// checked every cycle against a position-index reference model.
module tb_led_flow_ctrl;

  logic       clk50MHz = 1'b0;
  logic       rst      = 1'b1;
  logic [1:0] mode     = 2'd0;
  logic [1:0] speed    = 2'd0;
  logic       pause    = 1'b0;
  logic [7:0] led8;
  logic [3:0] led4;
  logic       step8, step4;

  int n_err = 0;
  int n_chk = 0;

  led_flow_ctrl #(.LED_W(8), .STEP_CYC(16)) dut8 (
    .clk50MHz(clk50MHz), .rst(rst), .mode(mode), .speed(speed),
    .pause(pause), .led(led8), .step(step8));

  led_flow_ctrl #(.LED_W(4), .STEP_CYC(16)) dut4 (
    .clk50MHz(clk50MHz), .rst(rst), .mode(mode), .speed(speed),
    .pause(pause), .led(led4), .step(step4));

  always #10 clk50MHz = ~clk50MHz;

  // Reference model: pattern position per instance, shared period counter
  int       m_w[2] = '{8, 4};
  int       m_idx[2];
  int       m_cnt;
  bit       m_first;
  bit [1:0] m_mode;
  bit       m_step;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_chk++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  function automatic int m_led(input int k);
    int w = m_w[k];
    int i = m_idx[k];
    case (m_mode)
      2'd0, 2'd1: return 1 << i;
      2'd2:       return (i < w) ? (1 << i) : (1 << (2*w - 2 - i));
      default:    return (1 << (i + 1)) - 1;
    endcase
  endfunction

  function automatic int m_adv(input int k);
    int w = m_w[k];
    int i = m_idx[k];
    case (m_mode)
      2'd0:    return (i + 1) % w;
      2'd1:    return (i + w - 1) % w;
      2'd2:    return (i + 1) % (2*w - 2);
      default: return (i + 1) % w;
    endcase
  endfunction

  task automatic m_reset();
    m_idx[0] = 0; m_idx[1] = 0;
    m_cnt = 0; m_first = 1'b1; m_mode = 2'd0; m_step = 1'b0;
  endtask

  task automatic model_edge();
    if (m_first) begin
      m_first = 1'b0; m_mode = mode; m_step = 1'b0;
    end else if (mode != m_mode) begin
      m_mode = mode; m_idx[0] = 0; m_idx[1] = 0; m_cnt = 0; m_step = 1'b0;
    end else if (pause) begin
      m_step = 1'b0;
    end else if (m_cnt >= (16 >> speed) - 1) begin
      m_cnt = 0; m_idx[0] = m_adv(0); m_idx[1] = m_adv(1); m_step = 1'b1;
    end else begin
      m_cnt++; m_step = 1'b0;
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk50MHz);
      model_edge();
      @(negedge clk50MHz);
      chk("led8", 32'(led8), 32'(m_led(0)));
      chk("led4", 32'(led4), 32'(m_led(1)));
      chk("step8", 32'(step8), 32'(m_step));
      chk("step4", 32'(step4), 32'(m_step));
    end
  endtask

  task automatic do_reset(input logic [1:0] md);
    @(negedge clk50MHz);
    rst = 1'b1; mode = md; speed = 2'd0; pause = 1'b0;
    m_reset();
    @(posedge clk50MHz);
    @(negedge clk50MHz);
    chk("rst_led8", 32'(led8), 32'h1);
    chk("rst_step8", 32'(step8), 32'h0);
    rst = 1'b0;
  endtask

  initial begin
    int k;
    m_reset();
    // Rotate-left from reset: step k lands 1 + 16k edges after release
    do_reset(2'd0);
    cyc(17);      chk("rol_s1", 32'(led8), 32'h02);
    cyc(16*6);    chk("rol_s7", 32'(led8), 32'h80);
    cyc(16);      chk("rol_s8", 32'(led8), 32'h01);

    // Ping-pong from reset, both widths
    do_reset(2'd2);
    cyc(1 + 16*3); chk("png4_s3", 32'(led4), 32'h8);
    cyc(16*3);     chk("png4_s6", 32'(led4), 32'h1);
    cyc(16);       chk("png_s7", 32'(led8), 32'h80);
    cyc(16);       chk("png_s8", 32'(led8), 32'h40);
    cyc(16*6);     chk("png_s14", 32'(led8), 32'h01);

    // Fill via mode change: reload edge, then step k after 16k edges
    mode = 2'd3;
    cyc(1);        chk("fil_rld", 32'(led8), 32'h01);
    cyc(16*7);     chk("fil_s7", 32'(led8), 32'hFF);
    cyc(16);       chk("fil_s8", 32'(led8), 32'h01);

    // Fast rate with pause and resume
    speed = 2'd3;
    cyc(10);
    pause = 1'b1; cyc(10);
    pause = 1'b0; cyc(10);

    // Speed cut at count 9 steps on the next edge
    speed = 2'd0;
    k = 0;
    while (m_cnt != 9 && k < 64) begin cyc(1); k++; end
    chk("cnt9_reached", 32'(k < 64), 32'h1);
    speed = 2'd3;
    cyc(1);        chk("spd_cut_step", 32'(step8), 32'h1);
    speed = 2'd0;

    // Mode change at led 20 reloads without a step, next step gives 80
    mode = 2'd0;
    k = 0;
    while (m_led(0) != 32'h20 && k < 256) begin cyc(1); k++; end
    chk("led20_reached", 32'(k < 256), 32'h1);
    mode = 2'd1;
    cyc(1);
    chk("mchg_led", 32'(led8), 32'h01);
    chk("mchg_step", 32'(step8), 32'h0);
    cyc(16);       chk("mchg_s1", 32'(led8), 32'h80);

    // Mode change while paused still reloads and then holds
    cyc(20);
    pause = 1'b1; mode = 2'd2; cyc(5);
    chk("pause_rld", 32'(led8), 32'h01);
    pause = 1'b0; cyc(20);

    // Async reset right while step is high: outputs clear before next edge
    k = 0;
    while (!m_step && k < 64) begin cyc(1); k++; end
    chk("step_seen", 32'(k < 64), 32'h1);
    #2;
    rst = 1'b1;
    #1;
    chk("arst_led8", 32'(led8), 32'h01);
    chk("arst_led4", 32'(led4), 32'h1);
    chk("arst_step8", 32'(step8), 32'h0);
    m_reset();
    @(negedge clk50MHz);
    rst = 1'b0;
    cyc(40);

    // Randomized run
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 59) == 0) mode = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) speed = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 24) == 0) pause = ~pause;
      cyc(1);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
